// File: rtl/matmul_operand_loader_if.sv
// Element stream into the operand loader.
//   in_data  : matrix element (DATA_W bits)
//   in_valid : in_data is valid this cycle
//   in_ready : loader accepts a beat this cycle
// master = element source, slave = loader.
interface matmul_operand_loader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader
// Upstream feeder for the 1-to-12 operand demux of the matrix-multiply datapath.
// The first N_A accepted elements are steered to port 1 (sel1 = 0..N_A-1), the next
// N_B to port 2 (sel2 = 0..N_B-1). A clear request produces a single-cycle SEL_CLR
// strobe on both selectors with zero data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, clear_req    command pulses, sampled only while idle (start has priority)
//   in_s                element stream (slave side of matmul_operand_loader_if)
//   data_out1, sel1     demux port 1 (squared operand slots)
//   data_out2, sel2     demux port 2 (second operand slots)
//   busy                high whenever the loader is outside IDLE
//   done                one-cycle pulse once the last B element has been presented
// All data/selector outputs are registered; the demux samples them on the falling edge.
module matmul_operand_loader #(
  parameter int          DATA_W   = 16,
  parameter int          N_A      = 4,
  parameter int          N_B      = 6,
  parameter logic [2:0]  SEL_IDLE = 3'b110,
  parameter logic [2:0]  SEL_CLR  = 3'b111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear_req,
  matmul_operand_loader_if.slave in_s,
  output logic [DATA_W-1:0]     data_out1,
  output logic [2:0]            sel1,
  output logic [DATA_W-1:0]     data_out2,
  output logic [2:0]            sel2,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] LAST_A = 3'(N_A - 1);
  localparam logic [2:0] LAST_B = 3'(N_B - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_DONE   = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          sel1_q, sel1_d;
  logic [2:0]          sel2_q, sel2_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic [DATA_W-1:0]   data2_q, data2_d;
  logic                ready;
  logic                beat;

  // Handshake and status are decoded straight from the registered state, so they
  // change only at the rising edge like every other output.
  assign ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign beat  = ready & in_s.in_valid;

  assign in_s.in_ready = ready;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign sel1          = sel1_q;
  assign sel2          = sel2_q;
  assign data_out1     = data1_q;
  assign data_out2     = data2_q;

  // Selectors default to SEL_IDLE every cycle so each slot strobe lasts exactly one
  // cycle; data registers hold their value between beats.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel1_d  = SEL_IDLE;
    sel2_d  = SEL_IDLE;
    data1_d = data1_q;
    data2_d = data2_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end else if (clear_req) begin
          state_d = S_CLEAR;
          sel1_d  = SEL_CLR;
          sel2_d  = SEL_CLR;
          data1_d = '0;
          data2_d = '0;
        end
      end
      S_LOAD_A: begin
        if (beat) begin
          data1_d = in_s.in_data;
          sel1_d  = cnt_q;
          if (cnt_q == LAST_A) begin
            // Hand over to port 2 on the same edge: no bubble between A and B.
            state_d = S_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_LOAD_B: begin
        if (beat) begin
          data2_d = in_s.in_data;
          sel2_d  = cnt_q;
          if (cnt_q == LAST_B) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel1_q  <= SEL_IDLE;
      sel2_q  <= SEL_IDLE;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

endmodule

// File: tb/tb_matmul_operand_loader.sv
module tb_matmul_operand_loader;

  localparam int N_A = 4;
  localparam int N_B = 6;
  localparam logic [2:0] SEL_IDLE = 3'b110;
  localparam logic [2:0] SEL_CLR  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clear_req;
  logic [15:0] data_out1, data_out2;
  logic [2:0]  sel1, sel2;
  logic        busy, done;

  matmul_operand_loader_if #(.DATA_W(16)) s_if ();

  matmul_operand_loader #(
    .DATA_W(16), .N_A(N_A), .N_B(N_B), .SEL_IDLE(SEL_IDLE), .SEL_CLR(SEL_CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_req(clear_req),
    .in_s(s_if),
    .data_out1(data_out1), .sel1(sel1),
    .data_out2(data_out2), .sel2(sel2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 loading, 2 done, 3 clear; nbeat counts the
  // elements of the current sequence, which alone decides port and slot.
  int          mode, nbeat;
  logic [2:0]  m_sel1, m_sel2;
  logic [15:0] m_d1, m_d2;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt, done_cnt, clr_cnt;
  logic [2:0]  q1_sel[$], q2_sel[$];
  logic [15:0] q1_dat[$], q2_dat[$];

  // Stand-in for the downstream demux: port 1 slot s -> out s, port 2 slot s ->
  // out N_A+s, SEL_CLR zeroes outs 11/12 (indices 10/11). Captures on the falling edge.
  logic [15:0] dmx [12];
  logic        dmx_inited = 1'b0;
  always @(negedge clk) begin
    if (!dmx_inited) begin
      for (int i = 0; i < 12; i++) dmx[i] <= 16'hDEAD;
      dmx_inited <= 1'b1;
    end else begin
      if (sel1 < 3'd6) dmx[sel1] <= data_out1;
      if (sel2 < 3'd6 && (N_A + int'(sel2)) < 10) dmx[N_A + int'(sel2)] <= data_out2;
      if (sel1 == SEL_CLR || sel2 == SEL_CLR) begin
        dmx[10] <= 16'h0000;
        dmx[11] <= 16'h0000;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; nbeat = 0;
    m_sel1 = SEL_IDLE; m_sel2 = SEL_IDLE;
    m_d1 = 16'h0; m_d2 = 16'h0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_sel1 = SEL_IDLE;
      m_sel2 = SEL_IDLE;
      case (mode)
        0: begin
          if (start) begin
            mode = 1; nbeat = 0;
          end else if (clear_req) begin
            mode = 3; m_sel1 = SEL_CLR; m_sel2 = SEL_CLR; m_d1 = 16'h0; m_d2 = 16'h0;
          end
        end
        1: begin
          if (s_if.in_valid) begin
            if (nbeat < N_A) begin
              m_sel1 = 3'(nbeat); m_d1 = s_if.in_data;
            end else begin
              m_sel2 = 3'(nbeat - N_A); m_d2 = s_if.in_data;
            end
            nbeat++;
            if (nbeat == N_A + N_B) mode = 2;
          end
        end
        default: mode = 0;
      endcase
    end
  endtask

  task automatic check_cycle();
    chk("in_ready",  s_if.in_ready, (mode == 1));
    chk("busy",      busy,          (mode != 0));
    chk("done",      done,          (mode == 2));
    chk("sel1",      sel1,          m_sel1);
    chk("sel2",      sel2,          m_sel2);
    chk("data_out1", data_out1,     m_d1);
    chk("data_out2", data_out2,     m_d2);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (sel1 == SEL_CLR && sel2 == SEL_CLR) clr_cnt++;
    if (sel1 < 3'd6) begin q1_sel.push_back(sel1); q1_dat.push_back(data_out1); end
    if (sel2 < 3'd6) begin q2_sel.push_back(sel2); q2_dat.push_back(data_out2); end
  endtask

  // Inputs change 1 time unit after the falling edge; the model follows each rising edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_cycle();
    #1;
  endtask

  task automatic clear_logs();
    q1_sel.delete(); q1_dat.delete(); q2_sel.delete(); q2_dat.delete();
    busy_cnt = 0; done_cnt = 0; clr_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [15:0] base, input logic [15:0] stepv,
                            input bit gaps);
    int sent = 0;
    int budget = 0;
    bit alt = 1'b1;
    bit acc;
    while (sent < n && budget < 100) begin
      s_if.in_valid = gaps ? alt : 1'b1;
      s_if.in_data  = base + stepv * 16'(sent);
      alt = ~alt;
      acc = s_if.in_valid && s_if.in_ready;
      step();
      if (acc) sent++;
      budget++;
    end
    s_if.in_valid = 1'b0;
    s_if.in_data  = 16'h0;
    if (sent != n) chk("beat_budget", sent, n);
  endtask

  // Pins the strobe log of one full load against hand-computed slot/data pairs.
  task automatic check_log(input string tag, input logic [15:0] base, input logic [15:0] stepv);
    chk({tag, "_len1"}, q1_sel.size(), N_A);
    chk({tag, "_len2"}, q2_sel.size(), N_B);
    for (int i = 0; i < N_A && i < q1_sel.size(); i++) begin
      chk({tag, "_sel1"}, q1_sel[i], i);
      chk({tag, "_dat1"}, q1_dat[i], base + stepv * 16'(i));
    end
    for (int i = 0; i < N_B && i < q2_sel.size(); i++) begin
      chk({tag, "_sel2"}, q2_sel[i], i);
      chk({tag, "_dat2"}, q2_dat[i], base + stepv * 16'(N_A + i));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clear_req = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = 16'h0;
    model_reset();
    clear_logs();
    #1;
    repeat (3) step();
    chk("rst_sel1", sel1, 3'b110);
    chk("rst_sel2", sel2, 3'b110);
    chk("rst_ready", s_if.in_ready, 1'b0);
    rst_n = 1'b1;
    repeat (2) step();

    // Back-to-back load 0x0001..0x000A.
    clear_logs();
    pulse_start();
    send_beats(10, 16'h0001, 16'h0001, 1'b0);
    repeat (3) step();
    check_log("t1", 16'h0001, 16'h0001);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_cycles", busy_cnt, 11);   // 4 A + 6 B + 1 DONE

    // Same load with in_valid low on alternate cycles.
    clear_logs();
    pulse_start();
    send_beats(10, 16'h0001, 16'h0001, 1'b1);
    repeat (3) step();
    check_log("t2", 16'h0001, 16'h0001);
    chk("t2_done_cnt", done_cnt, 1);

    // Clear strobe from IDLE.
    clear_logs();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (3) step();
    chk("t3_clr_cnt", clr_cnt, 1);
    chk("t3_busy_cycles", busy_cnt, 1);

    // start+clear together: start wins; clear held during the load is ignored.
    clear_logs();
    start = 1'b1; clear_req = 1'b1;
    step();
    start = 1'b0;
    send_beats(10, 16'h0100, 16'h0003, 1'b0);
    clear_req = 1'b0;
    repeat (3) step();
    chk("t4_clr_cnt", clr_cnt, 0);
    chk("t4_done_cnt", done_cnt, 1);
    check_log("t4", 16'h0100, 16'h0003);

    // Reset after the fifth beat, then a fresh load restarts at slot 0.
    clear_logs();
    pulse_start();
    send_beats(5, 16'h0050, 16'h0001, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_sel1", sel1, 3'b110);
    chk("t5_rst_sel2", sel2, 3'b110);
    chk("t5_rst_d2", data_out2, 16'h0000);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_ready", s_if.in_ready, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("t5_no_done", done_cnt, 0);
    clear_logs();
    pulse_start();
    send_beats(10, 16'h0200, 16'h0001, 1'b0);
    repeat (2) step();
    check_log("t5", 16'h0200, 16'h0001);

    // Demux view: load 0x1111..0xAAAA, then clear.
    clear_logs();
    pulse_start();
    send_beats(10, 16'h1111, 16'h1111, 1'b0);
    repeat (2) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 10; i++) chk("t6_demux_out", dmx[i], 16'h1111 * 16'(i + 1));
    chk("t6_demux_out11", dmx[10], 16'h0000);
    chk("t6_demux_out12", dmx[11], 16'h0000);

    // Randomised traffic with occasional commands while busy.
    for (int c = 0; c < 3000; c++) begin
      start         = ($urandom_range(0, 15) == 0);
      clear_req     = ($urandom_range(0, 15) == 0);
      s_if.in_valid = ($urandom_range(0, 2) != 0);
      s_if.in_data  = 16'($urandom);
      step();
    end
    start = 1'b0; clear_req = 1'b0; s_if.in_valid = 1'b0;
    repeat (15) step();
    chk("end_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
